// File: rtl/audio_sd_pkg.sv
// Shared types and default constants for the SD-card audio sector streamer.
package audio_sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        READ,
        WAIT_SPACE
    } state_t;

    localparam int          SEC_WORDS_DEF  = 256;
    localparam logic [31:0] START_ADDR_DEF = 32'd8448;
    localparam logic [16:0] AUDIO_SEC_DEF  = 17'd104422;

endpackage

// File: rtl/audio_sd_edge_sync.sv
// Two-stage synchroniser for the read-engine busy flag plus rise/fall pulses.
module audio_sd_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [2:0] sync;

    // Stages 0/1 synchronise, stage 2 holds the previous value for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1:0], din};
        end
    end

    assign rise = sync[1] & ~sync[2];
    assign fall = ~sync[1] & sync[2];

endmodule

// File: rtl/audio_sd_stream_ctrl.sv
// Sector-streaming controller feeding SD-card audio into the sample FIFO.
// Define AUDIO_SD_LOOP_EN for gapless looping back to START_ADDR at end of image.
module audio_sd_stream_ctrl
    import audio_sd_pkg::*;
#(
    parameter int                SEC_W      = 17,
    parameter logic [31:0]       START_ADDR = START_ADDR_DEF,
    parameter logic [SEC_W-1:0]  AUDIO_SEC  = SEC_W'(AUDIO_SEC_DEF),
    parameter int                FIFO_AW    = 10,
    parameter int                HI_WM      = 767,
    parameter int                SEC_WORDS  = SEC_WORDS_DEF
) (
    input  logic               sd_clk,
    input  logic               rst,
    input  logic               sd_init_done,
    input  logic               play_en,
    input  logic               stop,
    input  logic               rd_busy,
    input  logic               rd_val_en,
    input  logic [15:0]        rd_val_data,
    input  logic [FIFO_AW-1:0] fifo_wrusedw,
    output logic               rd_start_en,
    output logic [31:0]        rd_sec_addr,
    output logic               fifo_wr_en,
    output logic [15:0]        fifo_wr_data,
    output logic [SEC_W-1:0]   sec_cnt,
    output logic               play_done,
    output logic               err_short,
    output logic               err_ovf
);

    localparam int                 WC_W      = $clog2(SEC_WORDS + 1);
    localparam logic [WC_W-1:0]    WORDS_MAX = WC_W'(SEC_WORDS);
    localparam logic [FIFO_AW-1:0] HI_WM_V   = FIFO_AW'(HI_WM);

    state_t           state, next_state;
    logic [SEC_W-1:0] sec_next, sec_inc;
    logic [WC_W-1:0]  word_cnt;
    logic             busy_rise, busy_fall;
    logic             space_ok, at_end;
    logic             done_next, short_set;
    logic             stop_pend, stop_pend_next;

    audio_sd_edge_sync u_busy_sync (
        .clk  (sd_clk),
        .rst  (rst),
        .din  (rd_busy),
        .rise (busy_rise),
        .fall (busy_fall)
    );

    assign space_ok    = (fifo_wrusedw <= HI_WM_V);
    assign sec_inc     = sec_cnt + SEC_W'(1);
    assign at_end      = (sec_inc == AUDIO_SEC);
    assign rd_start_en = (state == ISSUE);

    // A stop seen while a sector is in flight is deferred to the busy fall so the
    // engine is never left mid-transfer.
    always_comb begin
        next_state     = state;
        sec_next       = sec_cnt;
        done_next      = 1'b0;
        short_set      = 1'b0;
        stop_pend_next = stop_pend;
        case (state)
            IDLE: begin
                if (stop) begin
                    sec_next = '0;
                end else if (sd_init_done && play_en && space_ok && (sec_cnt != AUDIO_SEC)) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (stop) begin
                    next_state = IDLE;
                    sec_next   = '0;
                end else begin
                    next_state = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (stop) stop_pend_next = 1'b1;
                if (busy_rise) next_state = READ;
            end
            READ: begin
                if (stop) stop_pend_next = 1'b1;
                if (busy_fall) begin
                    short_set = (word_cnt < WORDS_MAX);
                    sec_next  = sec_inc;
                    if (stop || stop_pend) begin
                        next_state = IDLE;
                        sec_next   = '0;
                    end else if (at_end) begin
                        done_next = 1'b1;
`ifdef AUDIO_SD_LOOP_EN
                        sec_next   = '0;
                        next_state = WAIT_SPACE;
`else
                        next_state = IDLE;
`endif
                    end else if (!sd_init_done) begin
                        next_state = IDLE;
                    end else begin
                        next_state = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                if (stop) begin
                    next_state = IDLE;
                    sec_next   = '0;
                end else if (!sd_init_done) begin
                    next_state = IDLE;
                end else if (play_en && space_ok) begin
                    next_state = ISSUE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (next_state == IDLE) stop_pend_next = 1'b0;
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sec_cnt     <= '0;
            play_done   <= 1'b0;
            stop_pend   <= 1'b0;
            err_short   <= 1'b0;
            err_ovf     <= 1'b0;
            rd_sec_addr <= '0;
        end else begin
            state     <= next_state;
            sec_cnt   <= sec_next;
            play_done <= done_next;
            stop_pend <= stop_pend_next;
            if (short_set) err_short <= 1'b1;
            if (rd_val_en && (&fifo_wrusedw)) err_ovf <= 1'b1;
            if ((next_state == ISSUE) && (state != ISSUE)) begin
                rd_sec_addr <= START_ADDR + 32'(sec_cnt);
            end
        end
    end

    // Data can arrive before the synchronised rise reaches the FSM, so WAIT_BUSY counts too.
    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (state == ISSUE) begin
            word_cnt <= '0;
        end else if ((state == READ) && busy_fall) begin
            word_cnt <= '0;
        end else if (rd_val_en && ((state == WAIT_BUSY) || (state == READ)) && (word_cnt != WORDS_MAX)) begin
            word_cnt <= word_cnt + WC_W'(1);
        end
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
        end else begin
            fifo_wr_en   <= rd_val_en;
            fifo_wr_data <= {rd_val_data[7:0], rd_val_data[15:8]};
        end
    end

endmodule

// File: tb/tb_audio_sd_stream_ctrl.sv
// Directed self-checking bench for audio_sd_stream_ctrl with a 3-sector image;
// end-of-image expectations follow AUDIO_SD_LOOP_EN.
module tb_audio_sd_stream_ctrl;

    logic        sd_clk = 1'b0;
    logic        rst;
    logic        sd_init_done;
    logic        play_en;
    logic        stop;
    logic        rd_busy;
    logic        rd_val_en;
    logic [15:0] rd_val_data;
    logic [9:0]  fifo_wrusedw;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic [16:0] sec_cnt;
    logic        play_done;
    logic        err_short;
    logic        err_ovf;

    int passes      = 0;
    int checks      = 0;
    int wr_count    = 0;
    int done_count  = 0;
    int start_count = 0;

    always #5 sd_clk = ~sd_clk;

    audio_sd_stream_ctrl #(
        .SEC_W      (17),
        .START_ADDR (32'd8448),
        .AUDIO_SEC  (17'd3),
        .FIFO_AW    (10),
        .HI_WM      (767),
        .SEC_WORDS  (256)
    ) dut (
        .sd_clk       (sd_clk),
        .rst          (rst),
        .sd_init_done (sd_init_done),
        .play_en      (play_en),
        .stop         (stop),
        .rd_busy      (rd_busy),
        .rd_val_en    (rd_val_en),
        .rd_val_data  (rd_val_data),
        .fifo_wrusedw (fifo_wrusedw),
        .rd_start_en  (rd_start_en),
        .rd_sec_addr  (rd_sec_addr),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .sec_cnt      (sec_cnt),
        .play_done    (play_done),
        .err_short    (err_short),
        .err_ovf      (err_ovf)
    );

    always @(negedge sd_clk) begin
        if (fifo_wr_en)  wr_count++;
        if (play_done)   done_count++;
        if (rd_start_en) start_count++;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge sd_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic waitStart(input string tag, input int budget, input logic [31:0] exp_addr);
        logic        seen;
        logic [31:0] addr;
        seen = 1'b0;
        addr = '0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (rd_start_en) begin
                seen = 1'b1;
                addr = rd_sec_addr;
                break;
            end
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_addr"}, addr, exp_addr);
    endtask

    // Plays the read engine for one sector: busy up, nwords data beats, busy down.
    task automatic applyStimulus(input int nwords, input int stop_at);
        step();
        rd_busy = 1'b1;
        step();
        for (int i = 0; i < nwords; i++) begin
            rd_val_en   = 1'b1;
            rd_val_data = 16'(i);
            stop        = (i == stop_at);
            step();
        end
        rd_val_en = 1'b0;
        stop      = 1'b0;
        rd_busy   = 1'b0;
    endtask

    initial begin
        int wr_snap;
        int start_snap;
        rst          = 1'b1;
        sd_init_done = 1'b0;
        play_en      = 1'b0;
        stop         = 1'b0;
        rd_busy      = 1'b0;
        rd_val_en    = 1'b0;
        rd_val_data  = '0;
        fifo_wrusedw = '0;
        repeat (3) step();

        checkOutput("rst_start_en", 32'(rd_start_en), 32'd0);
        checkOutput("rst_addr",     rd_sec_addr,      32'd0);
        checkOutput("rst_wr_en",    32'(fifo_wr_en),  32'd0);
        checkOutput("rst_sec_cnt",  32'(sec_cnt),     32'd0);
        checkOutput("rst_done",     32'(play_done),   32'd0);
        checkOutput("rst_short",    32'(err_short),   32'd0);
        checkOutput("rst_ovf",      32'(err_ovf),     32'd0);
        rst = 1'b0;
        step();

        rd_val_en   = 1'b1;
        rd_val_data = 16'h1234;
        step();
        checkOutput("swap1_en",   32'(fifo_wr_en),   32'd1);
        checkOutput("swap1_data", 32'(fifo_wr_data), 32'h3412);
        rd_val_data = 16'hABCD;
        step();
        checkOutput("swap2_data", 32'(fifo_wr_data), 32'hCDAB);
        rd_val_en = 1'b0;
        play_en   = 1'b1;
        step();
        checkOutput("swap_wr_off", 32'(fifo_wr_en), 32'd0);
        repeat (5) step();
        checkOutput("no_init_no_start", 32'(start_count), 32'd0);
        wr_count = 0;

        sd_init_done = 1'b1;
        waitStart("sec0", 10, 32'd8448);
        applyStimulus(256, -1);
        fifo_wrusedw = 10'd800;
        repeat (20) step();
        checkOutput("throttle_starts", 32'(start_count), 32'd1);
        checkOutput("throttle_sec",    32'(sec_cnt),     32'd1);
        checkOutput("sec0_writes",     32'(wr_count),    32'd256);

        fifo_wrusedw = 10'd767;
        waitStart("sec1", 2, 32'd8449);
        play_en = 1'b0;
        applyStimulus(256, -1);
        repeat (20) step();
        checkOutput("pause_starts", 32'(start_count), 32'd2);
        checkOutput("pause_sec",    32'(sec_cnt),     32'd2);
        checkOutput("pause_writes", 32'(wr_count),    32'd512);

        play_en = 1'b1;
        waitStart("sec2", 3, 32'd8450);
        applyStimulus(256, -1);
`ifdef AUDIO_SD_LOOP_EN
        waitStart("loop", 10, 32'd8448);
        checkOutput("loop_done", 32'(done_count), 32'd1);
        checkOutput("loop_sec",  32'(sec_cnt),    32'd0);
`else
        repeat (20) step();
        checkOutput("end_done",   32'(done_count),  32'd1);
        checkOutput("end_sec",    32'(sec_cnt),     32'd3);
        checkOutput("end_starts", 32'(start_count), 32'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        checkOutput("end_stop_sec", 32'(sec_cnt), 32'd0);
        waitStart("replay", 3, 32'd8448);
`endif
        checkOutput("play_writes", 32'(wr_count),  32'd768);
        checkOutput("play_short",  32'(err_short), 32'd0);
        checkOutput("play_ovf",    32'(err_ovf),   32'd0);

        play_en = 1'b0;
        applyStimulus(256, 100);
        repeat (10) step();
        checkOutput("stop_writes", 32'(wr_count),    32'd1024);
        checkOutput("stop_sec",    32'(sec_cnt),     32'd0);
        checkOutput("stop_starts", 32'(start_count), 32'd4);
        checkOutput("stop_done",   32'(done_count),  32'd1);

        play_en = 1'b1;
        waitStart("after_stop", 3, 32'd8448);
        applyStimulus(200, -1);
        waitStart("after_short", 10, 32'd8449);
        checkOutput("short_flag", 32'(err_short), 32'd1);
        checkOutput("short_sec",  32'(sec_cnt),   32'd1);
        applyStimulus(256, -1);
        fifo_wrusedw = 10'd1023;
        repeat (6) step();
        checkOutput("short_sticky", 32'(err_short), 32'd1);
        checkOutput("full_sec",     32'(sec_cnt),   32'd2);

        rd_val_en   = 1'b1;
        rd_val_data = 16'h00FF;
        step();
        rd_val_en = 1'b0;
        checkOutput("ovf_wr_en", 32'(fifo_wr_en),   32'd1);
        checkOutput("ovf_data",  32'(fifo_wr_data), 32'hFF00);
        checkOutput("ovf_flag",  32'(err_ovf),      32'd1);
        repeat (5) step();
        checkOutput("ovf_hold_starts", 32'(start_count), 32'd6);

        fifo_wrusedw = 10'd0;
        waitStart("sec2b", 10, 32'd8450);
        step();
        rd_busy = 1'b1;
        step();
        rd_val_en = 1'b1;
        repeat (5) step();
        rd_val_en = 1'b0;
        play_en   = 1'b0;
        rst       = 1'b1;
        #1;
        wr_snap = wr_count;
        repeat (4) step();
        rd_busy = 1'b0;
        repeat (2) step();
        checkOutput("rrst_writes", 32'(wr_count),  32'(wr_snap));
        checkOutput("rrst_wr_en",  32'(fifo_wr_en), 32'd0);
        checkOutput("rrst_sec",    32'(sec_cnt),    32'd0);
        checkOutput("rrst_short",  32'(err_short),  32'd0);
        checkOutput("rrst_ovf",    32'(err_ovf),    32'd0);
        start_snap = start_count;
        rst = 1'b0;
        repeat (10) step();
        checkOutput("rrst_no_start", 32'(start_count), 32'(start_snap));
        checkOutput("rrst_start_en", 32'(rd_start_en), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
